// File: rtl/counter_n.sv
// Parametrised up/down counter with enable prescaler, wrap or saturate at the
// bounds, synchronous clear/load and one-cycle step and terminal-count pulses.
module counter_n #(
   parameter int unsigned              BIT_SZ   = 16,
   parameter logic [BIT_SZ-1:0]        MAX_VAL  = '1,
   parameter int unsigned              PRESCALE = 1,
   parameter bit                       SATURATE = 1'b0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              up_down,
   input  logic              clear,
   input  logic              load,
   input  logic [BIT_SZ-1:0] load_val,
   output logic [BIT_SZ-1:0] count,
   output logic              step,
   output logic              tc,
   output logic              at_max,
   output logic              at_zero
);

   localparam int unsigned     PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [BIT_SZ-1:0] ONE    = BIT_SZ'(1);

   logic [BIT_SZ-1:0] count_q, count_d;
   logic [PW-1:0]     pre_cnt_q, pre_cnt_d;
   logic              step_q, step_d;
   logic              tc_q, tc_d;

   // Bounds are compared before any +1/-1, so the arithmetic never overflows.
   always_comb begin
      count_d   = count_q;
      pre_cnt_d = pre_cnt_q;
      step_d    = 1'b0;
      tc_d      = 1'b0;
      if (clear) begin
         count_d   = '0;
         pre_cnt_d = '0;
      end else if (load) begin
         count_d   = (load_val > MAX_VAL) ? MAX_VAL : load_val;
         pre_cnt_d = '0;
      end else if (enable) begin
         if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d = '0;
            step_d    = 1'b1;
            if (up_down) begin
               if (count_q == MAX_VAL) begin
                  tc_d = 1'b1;
                  if (!SATURATE) count_d = '0;
               end else begin
                  count_d = count_q + ONE;
               end
            end else begin
               if (count_q == '0) begin
                  tc_d = 1'b1;
                  if (!SATURATE) count_d = MAX_VAL;
               end else begin
                  count_d = count_q - ONE;
               end
            end
         end else begin
            pre_cnt_d = pre_cnt_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q   <= '0;
         pre_cnt_q <= '0;
         step_q    <= 1'b0;
         tc_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         pre_cnt_q <= pre_cnt_d;
         step_q    <= step_d;
         tc_q      <= tc_d;
      end
   end

   assign count   = count_q;
   assign step    = step_q;
   assign tc      = tc_q;
   assign at_max  = (count_q == MAX_VAL);
   assign at_zero = (count_q == '0);

endmodule
